// File: rtl/ee354_project_pkg.sv
// Shared constants and types for the snake game blocks: direction codes,
// grid limits, start position and the head-stepper state encoding.
package ee354_project_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned GRID_MAX = 14;
  localparam int unsigned START_X  = 7;
  localparam int unsigned START_Y  = 7;

  typedef enum logic [1:0] {
    StIdle,
    StMoving,
    StHit
  } state_e;

  // Same-axis requests are either a reversal or a no-op, so both are dropped.
  function automatic logic dir_rejected(logic [1:0] req, logic [1:0] cur);
    return (req[1] == cur[1]) && ((req[0] != cur[0]) || (req == cur));
  endfunction

endpackage

// File: rtl/snake_head_stepper_if.sv
// Control and status bundle between the game FSM and the snake head stepper.
interface snake_head_stepper_if;

  logic       Run;
  logic       Restart;
  logic       SCEN_dir;
  logic [1:0] In_Dirn;
  logic [3:0] Head_X;
  logic [3:0] Head_Y;
  logic [1:0] Cur_Dirn;
  logic       Step;
  logic       Wall_Hit;

  modport master (
    output Run, Restart, SCEN_dir, In_Dirn,
    input  Head_X, Head_Y, Cur_Dirn, Step, Wall_Hit
  );

  modport slave (
    input  Run, Restart, SCEN_dir, In_Dirn,
    output Head_X, Head_Y, Cur_Dirn, Step, Wall_Hit
  );

endinterface

// File: rtl/snake_tick_gen.sv
// Step-rate divider: counts 0..TICK_DIV-1 while enabled and flags the last count.
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && !clear && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Moves the snake head one cell per tick in the committed direction, buffering
// one pending turn and stopping with a sticky flag when the head meets a wall.
module snake_head_stepper #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned GRID_MAX = ee354_project_pkg::GRID_MAX,
  parameter int unsigned START_X  = ee354_project_pkg::START_X,
  parameter int unsigned START_Y  = ee354_project_pkg::START_Y
) (
  input logic                 board_clk,
  input logic                 Reset,
  snake_head_stepper_if.slave sh
);

  import ee354_project_pkg::*;

  localparam logic [3:0] GridMaxC = 4'(GRID_MAX);
  localparam logic [3:0] StartXC  = 4'(START_X);
  localparam logic [3:0] StartYC  = 4'(START_Y);

  state_e     state_q, state_d;
  logic [3:0] head_x_q, head_x_d, head_y_q, head_y_d;
  logic [1:0] cur_dirn_q, cur_dirn_d, pend_dirn_q, pend_dirn_d;
  logic       pend_valid_q, pend_valid_d;
  logic       step_q, step_d;
  logic       wall_hit_q, wall_hit_d;

  logic       tick;
  logic [1:0] move_dirn;
  logic [3:0] next_x, next_y;
  logic       hit;

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .board_clk (board_clk),
    .Reset     (Reset),
    .en        (state_q == StMoving),
    .clear     (sh.Restart || !sh.Run),
    .tick      (tick)
  );

  // The step uses the direction as it will be after the pending turn commits.
  assign move_dirn = pend_valid_q ? pend_dirn_q : cur_dirn_q;

  always_comb begin
    next_x = head_x_q;
    next_y = head_y_q;
    hit    = 1'b0;
    unique case (move_dirn)
      DIR_UP:    if (head_y_q == 4'd0)      hit = 1'b1; else next_y = head_y_q - 4'd1;
      DIR_DOWN:  if (head_y_q >= GridMaxC)  hit = 1'b1; else next_y = head_y_q + 4'd1;
      DIR_LEFT:  if (head_x_q == 4'd0)      hit = 1'b1; else next_x = head_x_q - 4'd1;
      DIR_RIGHT: if (head_x_q >= GridMaxC)  hit = 1'b1; else next_x = head_x_q + 4'd1;
      default:   hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    cur_dirn_d   = cur_dirn_q;
    pend_dirn_d  = pend_dirn_q;
    pend_valid_d = pend_valid_q;
    wall_hit_d   = wall_hit_q;
    step_d       = 1'b0;

    if (sh.Restart) begin
      state_d      = StIdle;
      head_x_d     = StartXC;
      head_y_d     = StartYC;
      cur_dirn_d   = DIR_RIGHT;
      pend_valid_d = 1'b0;
      wall_hit_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sh.Run) state_d = StMoving;
        end
        StMoving: begin
          if (tick) begin
            if (pend_valid_q) begin
              cur_dirn_d   = pend_dirn_q;
              pend_valid_d = 1'b0;
            end
            if (hit) begin
              wall_hit_d = 1'b1;
              state_d    = StHit;
            end else begin
              head_x_d = next_x;
              head_y_d = next_y;
              step_d   = 1'b1;
            end
          end
          // Written after the tick handling so a same-cycle press waits a step.
          if (sh.SCEN_dir && !dir_rejected(sh.In_Dirn, cur_dirn_q)) begin
            pend_dirn_d  = sh.In_Dirn;
            pend_valid_d = 1'b1;
          end
          if (!(tick && hit) && !sh.Run) state_d = StIdle;
        end
        StHit: begin
          state_d = StHit;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      head_x_q     <= StartXC;
      head_y_q     <= StartYC;
      cur_dirn_q   <= DIR_RIGHT;
      pend_dirn_q  <= DIR_RIGHT;
      pend_valid_q <= 1'b0;
      step_q       <= 1'b0;
      wall_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      cur_dirn_q   <= cur_dirn_d;
      pend_dirn_q  <= pend_dirn_d;
      pend_valid_q <= pend_valid_d;
      step_q       <= step_d;
      wall_hit_q   <= wall_hit_d;
    end
  end

  assign sh.Head_X   = head_x_q;
  assign sh.Head_Y   = head_y_q;
  assign sh.Cur_Dirn = cur_dirn_q;
  assign sh.Step     = step_q;
  assign sh.Wall_Hit = wall_hit_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper with TICK_DIV=4: expected steps are queued with
// their cycle number and checked by a monitor whenever Step is seen.
module tb_snake_head_stepper;

  logic board_clk = 1'b0;
  logic Reset;

  always #5 board_clk = ~board_clk;

  snake_head_stepper_if sh ();

  snake_head_stepper #(
    .TICK_DIV (4),
    .GRID_MAX (14),
    .START_X  (7),
    .START_Y  (7)
  ) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .sh        (sh)
  );

  typedef struct {
    int cyc;
    int x;
    int y;
    int d;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge board_clk) cyc <= cyc + 1;

  task automatic push(input int c, input int x, input int y, input int d);
    exp_t e;
    e.cyc = c;
    e.x   = x;
    e.y   = y;
    e.d   = d;
    sb.push_back(e);
  endtask

  // Returns 1 ns after rising edge number n.
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int x, input int y, input int d,
                     input int w, input int s);
    n_tests++;
    if ({sh.Head_X, sh.Head_Y, sh.Cur_Dirn, sh.Wall_Hit, sh.Step} !==
        {4'(x), 4'(y), 2'(d), 1'(w), 1'(s)}) begin
      n_fail++;
      $display("FAIL %s: got head=(%0d,%0d) dir=%0d wall=%0d step=%0d, need (%0d,%0d) dir=%0d wall=%0d step=%0d",
               name, sh.Head_X, sh.Head_Y, sh.Cur_Dirn, sh.Wall_Hit, sh.Step, x, y, d, w, s);
    end
  endtask

  // Monitor: every Step pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge board_clk);
      if (sh.Step === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step: got step at cyc=%0d head=(%0d,%0d), need no step",
                   cyc, sh.Head_X, sh.Head_Y);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc || int'(sh.Head_X) != e.x || int'(sh.Head_Y) != e.y ||
              int'(sh.Cur_Dirn) != e.d) begin
            n_fail++;
            $display("FAIL step: got cyc=%0d head=(%0d,%0d) dir=%0d, need cyc=%0d head=(%0d,%0d) dir=%0d",
                     cyc, sh.Head_X, sh.Head_Y, sh.Cur_Dirn, e.cyc, e.x, e.y, e.d);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, need finish before 100000 ns");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    Reset       = 1'b1;
    sh.Run      = 1'b0;
    sh.Restart  = 1'b0;
    sh.SCEN_dir = 1'b0;
    sh.In_Dirn  = 2'b00;
    #1;
    chk("reset_state", 7, 7, 3, 0, 0);

    // Free running to the right.
    at(2);
    Reset  = 1'b0;
    sh.Run = 1'b1;
    push(7, 8, 7, 3);
    push(11, 9, 7, 3);
    push(15, 10, 7, 3);

    // Left is a reversal and is dropped; up is taken at the next tick.
    push(19, 11, 7, 3);
    push(23, 11, 6, 0);
    at(16); sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b10;
    at(17); sh.SCEN_dir = 1'b0;
    at(20); sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b00;
    at(21); sh.SCEN_dir = 1'b0;

    // Restart lands on a tick cycle: no step, back to start.
    at(26); sh.Restart = 1'b1;
    at(27); sh.Restart = 1'b0;
    @(negedge board_clk);
    chk("restart_on_tick", 7, 7, 3, 0, 0);

    // Up then down between ticks: down overwrites; a press on a tick waits.
    push(32, 8, 7, 3);
    push(36, 8, 8, 1);
    push(40, 8, 9, 1);
    push(44, 9, 9, 3);
    at(32); sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b00;
    at(33); sh.In_Dirn = 2'b01;
    at(34); sh.SCEN_dir = 1'b0;
    at(39); sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b11;
    at(40); sh.SCEN_dir = 1'b0;

    // Run drops mid-period with a turn pending; presses in idle are ignored.
    push(54, 9, 8, 0);
    at(45); sh.Run = 1'b0; sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b00;
    at(46); sh.SCEN_dir = 1'b0;
    at(47); sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b01;
    at(48); sh.SCEN_dir = 1'b0;
    at(49); sh.Run = 1'b1;

    at(55); sh.Restart = 1'b1;
    at(56); sh.Restart = 1'b0;
    @(negedge board_clk);
    chk("restart_idle", 7, 7, 3, 0, 0);

    // Run into the right wall.
    for (int k = 0; k < 7; k++) push(61 + 4 * k, 8 + k, 7, 3);
    at(89);
    @(negedge board_clk);
    chk("wall_hit", 14, 7, 3, 1, 0);
    at(90); sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b00;
    at(91); sh.SCEN_dir = 1'b0;
    at(100);
    @(negedge board_clk);
    chk("hit_holds", 14, 7, 3, 1, 0);

    // Leave HIT, queue a turn, then reset asynchronously with counter at 2.
    at(101); sh.Restart = 1'b1;
    at(102); sh.Restart = 1'b0;
    push(107, 8, 7, 3);
    at(107); sh.SCEN_dir = 1'b1; sh.In_Dirn = 2'b00;
    at(108); sh.SCEN_dir = 1'b0;
    at(109); Reset = 1'b1;
    #1;
    chk("async_reset", 7, 7, 3, 0, 0);
    at(111); Reset = 1'b0;
    push(116, 8, 7, 3);

    at(118);
    @(negedge board_clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: got %0d steps outstanding, need 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
